w_serializer: RTL and testbench

W_SERIALIZER -- requirements
Module: w_serializer

---
 rtl/w_serializer.sv | 134 +++++++++++++
 tb/tb_w_serializer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/w_serializer.sv
// w_serializer: loads a WIDTH-bit word and shifts it out MSB first on w,
// holding each bit for DIV clock cycles. Three-state control
// (IDLE -> SHIFT -> DONE -> IDLE) with every output taken straight from a flop.
module w_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             w,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Terminal counts: last cycle of a bit, last bit of a word.
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             w_q, w_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  // Next-state and next-output logic for the serializer control.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sreg_d   = sreg_q;
    w_d      = w_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ready_d  = ready_q;
    case (state_q)
      ST_IDLE: begin
        w_d    = 1'b0;
        busy_d = 1'b0;
        if (load_valid && ready_q) begin
          // Accept: capture the word and put its MSB on w immediately.
          state_d  = ST_SHIFT;
          sreg_d   = load_data;
          w_d      = load_data[WIDTH-1];
          strobe_d = 1'b1;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
          div_d    = {DW{1'b0}};
          bit_d    = {BW{1'b0}};
        end else begin
          // Also the path that raises ready on the first edge out of reset.
          ready_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DW'(1);
        end else if (bit_q != BIT_LAST) begin
          // Bit period over: advance to the next bit (sreg[WIDTH-2] is it).
          sreg_d   = {sreg_q[WIDTH-2:0], 1'b0};
          w_d      = sreg_q[WIDTH-2];
          strobe_d = 1'b1;
          bit_d    = bit_q + BW'(1);
          div_d    = {DW{1'b0}};
        end else begin
          state_d = ST_DONE;
          w_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        w_d     = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: begin
        // Unreachable encoding: fall back to a quiet, not-ready IDLE.
        state_d = ST_IDLE;
        w_d     = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State, counter, shift register and output flops; async reset clears all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      div_q    <= {DW{1'b0}};
      bit_q    <= {BW{1'b0}};
      sreg_q   <= {WIDTH{1'b0}};
      w_q      <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sreg_q   <= sreg_d;
      w_q      <= w_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign load_ready = ready_q;
  assign w          = w_q;
  assign bit_strobe = strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_w_serializer.sv
// Testbench for w_serializer: five instances (DIV = 4,1,2,3,7, WIDTH = 8),
// each paired with a phase-based reference model checked every falling edge,
// plus directed scenarios with hand-computed expectations.
module tb_w_serializer;

  localparam int NI = 5;

  logic       clk;
  logic       rst_n;
  logic [7:0] ld     [NI];
  logic       lv     [NI];
  logic       rdy_o  [NI];
  logic       w_o    [NI];
  logic       stb_o  [NI];
  logic       busy_o [NI];
  logic       done_o [NI];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Single comparison point: counts and reports.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_i
    localparam int D = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 3 : 7;

    w_serializer #(.WIDTH(8), .DIV(D)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_data  (ld[g]),
      .load_valid (lv[g]),
      .load_ready (rdy_o[g]),
      .w          (w_o[g]),
      .bit_strobe (stb_o[g]),
      .busy       (busy_o[g]),
      .done       (done_o[g])
    );

    // Model: ph = cycles since accept (-1 when idle). Bit k of the word
    // (MSB first) occupies phases k*D .. k*D+D-1; phase 8*D is the done cycle.
    int         ph  = -1;
    bit         rdy = 1'b0;
    logic [7:0] wd  = 8'h00;
    int         nw  = 0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ph  <= -1;
        rdy <= 1'b0;
      end else if (ph < 0) begin
        if (lv[g] && rdy) begin
          ph  <= 0;
          rdy <= 1'b0;
          wd  <= ld[g];
          nw  <= nw + 1;
        end else begin
          rdy <= 1'b1;
        end
      end else if (ph < 8 * D) begin
        ph <= ph + 1;
      end else begin
        ph  <= -1;
        rdy <= 1'b1;
      end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
      logic e_w, e_s, e_b, e_d, e_r;
      if (chk_en) begin
        e_w = 1'b0; e_s = 1'b0; e_b = 1'b0; e_d = 1'b0; e_r = 1'b0;
        if (ph >= 0 && ph < 8 * D) begin
          e_w = wd[7 - ph / D];
          e_s = ((ph % D) == 0);
          e_b = 1'b1;
        end else if (ph == 8 * D) begin
          e_d = 1'b1;
        end else begin
          e_r = rdy;
        end
        check($sformatf("w[div%0d]", D),     {31'd0, w_o[g]},    {31'd0, e_w});
        check($sformatf("strobe[div%0d]", D), {31'd0, stb_o[g]},  {31'd0, e_s});
        check($sformatf("busy[div%0d]", D),   {31'd0, busy_o[g]}, {31'd0, e_b});
        check($sformatf("done[div%0d]", D),   {31'd0, done_o[g]}, {31'd0, e_d});
        check($sformatf("ready[div%0d]", D),  {31'd0, rdy_o[g]},  {31'd0, e_r});
      end
    end
  end

  // Offer one word on instance g, collect the bits seen at each strobe,
  // the number of strobe-high cycles and the accept-to-done distance.
  task automatic capture(input int g, input logic [7:0] data, input bit poke,
                         output logic [7:0] bits, output int nstb, output int dcyc);
    int c;
    bit ok;
    bits = 8'h00; nstb = 0; dcyc = -1; ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = rdy_o[g];
    end
    check("wait_ready", {31'd0, ok}, 32'd1);
    lv[g] = 1'b1;
    ld[g] = data;
    c = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (poke && c >= 5 && c <= 12) begin
        lv[g] = 1'b1;
        ld[g] = 8'h0F ^ 8'(c);
      end else begin
        lv[g] = 1'b0;
      end
      if (stb_o[g]) begin
        bits = {bits[6:0], w_o[g]};
        nstb++;
      end
      if (done_o[g]) begin
        dcyc = c;
        break;
      end
      c++;
    end
  endtask

  initial begin
    logic [7:0] bits;
    int nstb, dcyc, k, a2, ndone, total;
    bit ok;
    rst_n = 1'b1;
    for (int g = 0; g < NI; g++) begin
      lv[g] = 1'b0;
      ld[g] = 8'h00;
    end
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_ready", {31'd0, rdy_o[0]}, 32'd0);
    check("rst_w",     {31'd0, w_o[0]},   32'd0);
    check("rst_busy",  {31'd0, busy_o[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", {31'd0, rdy_o[0]}, 32'd0);
    @(posedge clk);
    #1 check("ready_after_edge", {31'd0, rdy_o[0]}, 32'd1);

    // DIV=4, 0101_1100: eight strobes, done 32 cycles after accept.
    capture(0, 8'b0101_1100, 1'b0, bits, nstb, dcyc);
    check("d4_bits", {24'd0, bits}, 32'h5C);
    check("d4_strobes", nstb, 32'd8);
    check("d4_done_cyc", dcyc, 32'd32);

    // DIV=1, A5: strobe high for all 8 cycles, done at 8, then ready.
    capture(1, 8'hA5, 1'b0, bits, nstb, dcyc);
    check("d1_bits", {24'd0, bits}, 32'hA5);
    check("d1_strobes", nstb, 32'd8);
    check("d1_done_cyc", dcyc, 32'd8);
    @(negedge clk);
    check("d1_ready_after_done", {31'd0, rdy_o[1]}, 32'd1);

    // Loads offered mid-word must not disturb the word in flight.
    capture(0, 8'h3C, 1'b1, bits, nstb, dcyc);
    check("ignore_bits", {24'd0, bits}, 32'h3C);
    check("ignore_done_cyc", dcyc, 32'd32);

    // Back-to-back with load_valid held: FF then 00, spacing 34.
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = rdy_o[0];
    end
    lv[0] = 1'b1;
    ld[0] = 8'hFF;
    a2 = -1;
    for (k = 1; k < 200; k++) begin
      @(negedge clk);
      ld[0] = 8'h00;
      if (rdy_o[0]) begin
        a2 = k;
        check("b2b_w_idle", {31'd0, w_o[0]}, 32'd0);
        break;
      end
    end
    check("b2b_spacing", a2, 32'd34);
    @(negedge clk);
    lv[0] = 1'b0;
    for (int i = 0; i < 60; i++) @(negedge clk);

    // Async reset at bit 3 of F0 (bit 3 is a 1): outputs drop before any edge.
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = rdy_o[0];
    end
    lv[0] = 1'b1;
    ld[0] = 8'hF0;
    @(negedge clk);
    lv[0] = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("pre_rst_w", {31'd0, w_o[0]}, 32'd1);
    check("pre_rst_strobe", {31'd0, stb_o[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_w",      {31'd0, w_o[0]},    32'd0);
    check("async_busy",   {31'd0, busy_o[0]}, 32'd0);
    check("async_strobe", {31'd0, stb_o[0]},  32'd0);
    check("async_ready",  {31'd0, rdy_o[0]},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o[0]) ndone++;
    end
    check("no_done_after_abort", ndone, 32'd0);
    capture(0, 8'h81, 1'b0, bits, nstb, dcyc);
    check("post_rst_bits", {24'd0, bits}, 32'h81);

    // Random traffic on all instances, data changing freely mid-word.
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        lv[g] = ($urandom_range(0, 3) != 0);
        ld[g] = 8'($urandom);
      end
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) lv[g] = 1'b0;
    for (int i = 0; i < 80; i++) @(negedge clk);
    total = g_i[0].nw + g_i[1].nw + g_i[2].nw + g_i[3].nw + g_i[4].nw;
    check("enough_words", {31'd0, (total >= 1000)}, 32'd1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
